// File: rtl/i2s_transmit_24.sv
// Stereo I2S transmitter framed by an external SCK/WS pair.
// Holds one stereo pair and shifts it out MSB-first, one SCK after each WS edge.
module i2s_transmit_24 #(
  parameter int DATA_WIDTH  = 24,
  parameter int SLOT_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sck_i,
  input  logic                  ws_i,
  input  logic [DATA_WIDTH-1:0] left_i,
  input  logic [DATA_WIDTH-1:0] right_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  sd_o,
  output logic                  frame_start_o,
  output logic                  underrun_o
);

  localparam int PAD_WIDTH = SLOT_WIDTH - DATA_WIDTH;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic                   sck_s;
  logic                   ws_s;
  logic                   sck_prev;
  logic                   ws_last;
  logic                   sck_fall;
  logic                   ws_chg;
  logic                   left_start;
  logic                   accept;
  logic                   hold_full;
  logic                   hold_full_nxt;
  logic                   started;
  logic [DATA_WIDTH-1:0]  hold_l;
  logic [DATA_WIDTH-1:0]  hold_r;
  logic [DATA_WIDTH-1:0]  active_r;
  logic [DATA_WIDTH-1:0]  chan_word;
  logic [SLOT_WIDTH-1:0]  shift;

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign ws_s       = ws_sync[SYNC_STAGES-1];
  assign sck_fall   = sck_prev & ~sck_s;
  assign ws_chg     = sck_fall & (ws_s != ws_last);
  assign left_start = ws_chg & ~ws_s;
  assign accept     = valid_i & ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck_i};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], ws_i};
      sck_prev <= sck_s;
    end
  end

  // Left slot takes the held pair directly; right slot replays the latched right sample.
  always_comb begin
    chan_word     = '0;
    hold_full_nxt = hold_full;
    if (left_start) begin
      if (hold_full) chan_word = hold_l;
    end else if (started) begin
      chan_word = active_r;
    end
    if (left_start) hold_full_nxt = 1'b0;
    if (accept)     hold_full_nxt = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sd_o          <= 1'b0;
      ready_o       <= 1'b1;
      frame_start_o <= 1'b0;
      underrun_o    <= 1'b0;
      shift         <= '0;
      active_r      <= '0;
      hold_l        <= '0;
      hold_r        <= '0;
      hold_full     <= 1'b0;
      ws_last       <= 1'b0;
      started       <= 1'b0;
    end else begin
      hold_full     <= hold_full_nxt;
      ready_o       <= ~hold_full_nxt;
      frame_start_o <= left_start;
      underrun_o    <= left_start & ~hold_full & started;
      if (accept) begin
        hold_l <= left_i;
        hold_r <= right_i;
      end
      if (sck_fall) begin
        sd_o    <= shift[SLOT_WIDTH-1];
        ws_last <= ws_s;
        if (ws_chg) shift <= {chan_word, {PAD_WIDTH{1'b0}}};
        else        shift <= shift << 1;
      end
      if (left_start) begin
        started  <= 1'b1;
        active_r <= hold_full ? hold_r : '0;
      end
    end
  end

endmodule

// File: doc/i2s_transmit_24.md
Name: i2s_transmit_24

Overview:
I2S transmitter, the output-side counterpart of the 24-bit I2S capture path. It accepts stereo 24-bit samples through a valid/ready handshake and serialises them MSB-first onto sd_o. Framing follows the SCK/WS pair produced by the shared I2S clock generator, so transmit and capture stay frame-aligned. It feeds an external DAC/codec or a loopback test path.

Parameters:
DATA_WIDTH, 24, sample bits per channel.
SLOT_WIDTH, 32, SCK periods per channel slot; bits after DATA_WIDTH are zero-filled.
SYNC_STAGES, 2, synchroniser depth for sck_i and ws_i.

Ports:
clk_i  in  1  system clock; single clock domain.
rst_ni  in  1  asynchronous, active-low reset.
sck_i  in  1  I2S bit clock from the clock generator; treated as asynchronous.
ws_i  in  1  I2S word select: 0 = left, 1 = right. Changes on the SCK falling edge.
left_i  in  DATA_WIDTH  signed left sample.
right_i  in  DATA_WIDTH  signed right sample.
valid_i  in  1  stereo pair valid.
ready_o  out  1  holding register empty; a transfer occurs when valid_i && ready_o.
sd_o  out  1  serial data, updated on SCK falling edges.
frame_start_o  out  1  one-clk_i pulse at each left-slot start.
underrun_o  out  1  one-clk_i pulse when a frame starts with no pair held.

Behaviour:
- Reset values (asynchronous): sd_o=0, ready_o=1, frame_start_o=0, underrun_o=0. Shift register, active regs, holding reg and ws_last are all 0. The started flag is 0.
- sck_i and ws_i each pass through SYNC_STAGES flops. A falling edge of synced sck produces sck_fall, which lasts one clk_i cycle. Required clock ratio: clk_i ≥ 4× SCK.
- Holding register:
  - One stereo pair, loaded on valid_i && ready_o.
  - ready_o = ~hold_full, registered.
  - hold_full clears when its pair is consumed at frame start.
- On each sck_fall:
  - sd_o <= shift[SLOT_WIDTH-1].
  - ws_chg = (ws_s != ws_last); then ws_last <= ws_s.
  - If ws_chg: shift <= {chan_word, zeros}. Otherwise shift <= shift << 1, with zero fill.
  - Result: the MSB appears on sd_o exactly one SCK after the WS transition, as the I2S standard requires. The previous slot's LSB position is sent on the change edge.
- Left start (ws_chg && ws_s==0):
  - frame_start_o pulses; started <= 1.
  - If hold_full: active_l/active_r <= holding; hold_full <= 0; chan_word = holding left.
  - Else: active_l/active_r <= 0; chan_word = 0; underrun_o pulses, but only if started was already 1.
- Right start (ws_chg && ws_s==1): chan_word = active_r if started, else 0.
- Until the first left start after reset, sd_o transmits only zeros. A right slot that begins before the first left start sends zeros.
- Simultaneous events:
  - Handshake in the same cycle as a left start with hold_full=0: the frame is an underrun (zeros), and the new pair is latched for the next frame.
  - With hold_full=1, ready_o=0, so no accept is possible in that cycle.
- Between sck_fall events all state holds. sd_o changes only on sck_fall cycles, plus reset.
- Reset asserted mid-frame: sd_o goes to 0 immediately. After release, the block waits for the next left start; no partial word is emitted.
- Widths: active samples are sent unmodified in two's complement. Padding bits are always 0.

Test Plan:
- Reset then idle with valid_i=0 for 3 frames: sd_o stays 0; underrun_o pulses on the 2nd and 3rd left starts, not the 1st; ready_o=1 throughout.
- Load left=24'hABCDEF, right=24'h123456 before the first left start. Left slot bits 1..24 after the WS fall read 0xABCDEF MSB-first, followed by 8 zeros. Right slot carries 0x123456. frame_start_o pulses once; ready_o returns to 1 after that left start.
- Back-to-back pairs (L=24'h800000,R=24'h7FFFFF) then (L=24'h000001,R=24'hFFFFFF), offered each frame: both frames serialise bit-exactly, with no underrun and no pair dropped. The second pair is held while ready_o=0.
- valid_i is driven in the exact clk_i cycle of a left start with the holding register empty: that frame sends zeros and underrun_o=1; the offered pair appears in the following frame.
- Reset is asserted in the middle of a left slot carrying 24'h5A5A5A: sd_o goes to 0 immediately and ready_o=1. After release, nothing is sent until the next WS falling edge.
- Loopback: connect sd_o to an i2s_capture_24 instance sharing sck/ws and send 16 random pairs. The captured left/right values equal the sent values, with a fixed one-frame latency.
